// File: rtl/rv32_dbus_bridge_if.sv
// Purpose : groups the memory-stage data port, the external req/ack data bus
//           and the fault report of rv32_dbus_bridge into one bundle.
// Modports: master = the bridge (drives the bus request, stall and fault),
//           slave  = the surrounding core/bus environment.
interface rv32_dbus_bridge_if;
  // pipeline / memory-stage side
  logic        stall_in;
  logic        core_read_in;
  logic        core_write_in;
  logic [3:0]  core_write_mask_in;
  logic [31:0] core_address_in;
  logic [31:0] core_write_value_in;
  logic [31:0] core_read_value_out;
  logic        stall_out;
  // external data bus side
  logic        bus_req_out;
  logic        bus_write_out;
  logic [3:0]  bus_sel_out;
  logic [31:0] bus_address_out;
  logic [31:0] bus_write_value_out;
  logic        bus_ack_in;
  logic        bus_error_in;
  logic [31:0] bus_read_value_in;
  // fault report
  logic        fault_out;
  logic [31:0] fault_address_out;

  modport master (
    input  stall_in, core_read_in, core_write_in, core_write_mask_in,
           core_address_in, core_write_value_in,
    output core_read_value_out, stall_out,
    output bus_req_out, bus_write_out, bus_sel_out, bus_address_out,
           bus_write_value_out,
    input  bus_ack_in, bus_error_in, bus_read_value_in,
    output fault_out, fault_address_out
  );

  modport slave (
    output stall_in, core_read_in, core_write_in, core_write_mask_in,
           core_address_in, core_write_value_in,
    input  core_read_value_out, stall_out,
    input  bus_req_out, bus_write_out, bus_sel_out, bus_address_out,
           bus_write_value_out,
    output bus_ack_in, bus_error_in, bus_read_value_in,
    input  fault_out, fault_address_out
  );
endinterface

// File: rtl/rv32_dbus_bridge.sv
// Purpose     : bridges the single-cycle memory-stage data port onto a req/ack
//               bus with wait states; one bus transaction per core access.
// Latency     : request in IDLE at cycle 0, bus_req_out from cycle 1, ack at
//               cycle 1+N gives DONE (data valid, stall released) at cycle 2+N.
// Backpressure: stall_out holds the pipeline until ack/error/timeout; DONE is
//               held (no reissue, data stable) while stall_in stays high.
// Ports: clk, reset_n (async active-low), dbus (rv32_dbus_bridge_if.master):
//        core_* / stall_* toward the pipeline, bus_* toward the data bus,
//        fault_out / fault_address_out report timeouts and bus errors.
module rv32_dbus_bridge #(
  parameter int unsigned TIMEOUT = 255  // max REQ cycles; 0 disables watchdog
) (
  input  logic               clk,
  input  logic               reset_n,
  rv32_dbus_bridge_if.master dbus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam int unsigned CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  logic [1:0]       state_q;
  logic [CNT_W-1:0] wd_cnt_q;
  logic [31:0]      addr_q;
  logic [31:0]      wdata_q;
  logic [3:0]       sel_q;
  logic             write_q;
  logic [31:0]      rdata_q;
  logic             fault_q;
  logic [31:0]      fault_addr_q;

  logic core_req;
  logic wd_expired;
  logic abort;

  assign core_req   = dbus.core_read_in | dbus.core_write_in;
  // The last allowed REQ cycle still honours an ack arriving in that cycle.
  assign wd_expired = (TIMEOUT != 0) && (wd_cnt_q == CNT_LAST);
  assign abort      = dbus.bus_error_in | (wd_expired & ~dbus.bus_ack_in);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      wd_cnt_q     <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      sel_q        <= '0;
      write_q      <= 1'b0;
      rdata_q      <= '0;
      fault_q      <= 1'b0;
      fault_addr_q <= '0;
    end else begin
      fault_q <= 1'b0;  // single-cycle pulse on DONE entry after a fault
      case (state_q)
        S_IDLE: begin
          if (core_req) begin
            addr_q   <= dbus.core_address_in;
            wdata_q  <= dbus.core_write_value_in;
            write_q  <= dbus.core_write_in;  // store wins over load
            sel_q    <= dbus.core_write_in ? dbus.core_write_mask_in : 4'b1111;
            wd_cnt_q <= '0;
            state_q  <= S_REQ;
          end
        end
        S_REQ: begin
          wd_cnt_q <= wd_cnt_q + 1'b1;
          if (abort) begin
            rdata_q      <= '0;
            fault_q      <= 1'b1;
            fault_addr_q <= addr_q;
            state_q      <= S_DONE;
          end else if (dbus.bus_ack_in) begin
            if (!write_q) rdata_q <= dbus.bus_read_value_in;
            state_q <= S_DONE;
          end
        end
        S_DONE: begin
          // Pipeline still frozen: hold result and never reissue.
          if (!dbus.stall_in) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign dbus.stall_out           = (state_q == S_REQ) | ((state_q == S_IDLE) & core_req);
  assign dbus.bus_req_out         = (state_q == S_REQ);
  assign dbus.bus_write_out       = write_q;
  assign dbus.bus_sel_out         = sel_q;
  assign dbus.bus_address_out     = {addr_q[31:2], 2'b00};
  assign dbus.bus_write_value_out = wdata_q;
  assign dbus.core_read_value_out = (state_q == S_DONE) ? rdata_q : 32'd0;
  assign dbus.fault_out           = fault_q;
  assign dbus.fault_address_out   = fault_addr_q;

endmodule

// File: tb/tb_rv32_dbus_bridge.sv
// Purpose     : self-checking bench for rv32_dbus_bridge; directed cases plus
//               randomized accesses checked against a per-transaction model.
// Latency     : n/a (bench).
// Backpressure: bench drives stall_in high until it chooses to release DONE.
module tb_rv32_dbus_bridge;
  localparam int TO = 4;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  rv32_dbus_bridge_if dif();

  rv32_dbus_bridge #(.TIMEOUT(TO)) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .dbus   (dif)
  );

  int n_cmp = 0;
  int n_mis = 0;

  // model state: what the memory stage should see in DONE, last fault address
  logic [31:0] exp_rd = 32'd0;
  logic [31:0] exp_fa = 32'd0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic rand_core();
    dif.core_read_in        = 1'($urandom);
    dif.core_write_in       = 1'($urandom);
    dif.core_write_mask_in  = 4'($urandom);
    dif.core_address_in     = $urandom;
    dif.core_write_value_in = $urandom;
  endtask

  task automatic quiet_inputs();
    dif.core_read_in  = 1'b0;
    dif.core_write_in = 1'b0;
    dif.bus_ack_in    = 1'b0;
    dif.bus_error_in  = 1'b0;
    dif.stall_in      = 1'b0;
  endtask

  // One complete access starting in IDLE. Bus answers with ack after `waits`
  // wait states, error in REQ cycle `err_at` (-1 = never); DONE held `hold`
  // extra cycles by stall_in.
  task automatic access(input bit wr, input logic [31:0] addr, input logic [3:0] mask,
                        input logic [31:0] wd, input logic [31:0] rdat,
                        input int waits, input int err_at, input int hold);
    int last;
    bit fault;
    logic [3:0] sel;
    sel  = wr ? mask : 4'hf;
    // transaction ends at the first of: ack, error, final watchdog cycle
    last = TO - 1;
    if (waits < last) last = waits;
    if (err_at >= 0 && err_at < last) last = err_at;
    fault = (err_at == last) || (waits != last);

    // cycle 0: IDLE, request presented (stray bus responses must be ignored)
    dif.core_write_in       = wr;
    dif.core_read_in        = wr ? 1'($urandom) : 1'b1;
    dif.core_write_mask_in  = mask;
    dif.core_address_in     = addr;
    dif.core_write_value_in = wd;
    dif.stall_in            = 1'b1;
    dif.bus_ack_in          = 1'($urandom);
    dif.bus_error_in        = 1'($urandom);
    dif.bus_read_value_in   = $urandom;
    #1;
    chk("idle_stall", 32'(dif.stall_out), 32'd1);
    chk("idle_req", 32'(dif.bus_req_out), 32'd0);
    chk("idle_rdval", dif.core_read_value_out, 32'd0);
    step();

    for (int k = 0; k <= last; k++) begin
      rand_core();  // latched request must not follow the core
      dif.bus_ack_in        = (k == waits);
      dif.bus_error_in      = (k == err_at);
      dif.bus_read_value_in = (k == waits) ? rdat : $urandom;
      #1;
      chk("req_req", 32'(dif.bus_req_out), 32'd1);
      chk("req_stall", 32'(dif.stall_out), 32'd1);
      chk("req_addr", dif.bus_address_out, {addr[31:2], 2'b00});
      chk("req_sel", 32'(dif.bus_sel_out), 32'(sel));
      chk("req_wr", 32'(dif.bus_write_out), 32'(wr));
      chk("req_wdata", dif.bus_write_value_out, wd);
      chk("req_rdval", dif.core_read_value_out, 32'd0);
      chk("req_fault", 32'(dif.fault_out), 32'd0);
      step();
    end

    if (fault) begin
      exp_rd = 32'd0;
      exp_fa = addr;
    end else if (!wr) begin
      exp_rd = rdat;
    end

    for (int h = 0; h <= hold; h++) begin
      dif.stall_in          = (h < hold);
      dif.bus_ack_in        = 1'($urandom);
      dif.bus_error_in      = 1'($urandom);
      dif.bus_read_value_in = $urandom;
      rand_core();
      #1;
      chk("done_stall", 32'(dif.stall_out), 32'd0);
      chk("done_req", 32'(dif.bus_req_out), 32'd0);
      chk("done_rdval", dif.core_read_value_out, exp_rd);
      chk("done_fault", 32'(dif.fault_out), 32'((h == 0) && fault));
      chk("done_faddr", dif.fault_address_out, exp_fa);
      step();
    end
  endtask

  initial begin
    quiet_inputs();
    dif.core_write_mask_in  = 4'h0;
    dif.core_address_in     = 32'd0;
    dif.core_write_value_in = 32'd0;
    dif.bus_read_value_in   = 32'd0;
    #1;
    chk("rst_req", 32'(dif.bus_req_out), 32'd0);
    chk("rst_stall", 32'(dif.stall_out), 32'd0);
    chk("rst_fault", 32'(dif.fault_out), 32'd0);
    chk("rst_faddr", dif.fault_address_out, 32'd0);
    chk("rst_rdval", dif.core_read_value_out, 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    step();

    // zero-wait read, unaligned byte address
    access(1'b0, 32'h0000_1006, 4'h0, 32'h0, 32'hA1B2_C3D4, 0, -1, 0);
    // write with 3 wait states (ack lands in the last watchdog cycle)
    access(1'b1, 32'h0000_0020, 4'b0100, 32'h00EE_0000, 32'h0, 3, -1, 0);
    // stall hold: DONE kept 6 cycles, then IDLE with no request
    access(1'b0, 32'h0000_0104, 4'h0, 32'h0, 32'h1234_5678, 1, -1, 6);
    quiet_inputs();
    #1;
    chk("post_hold_stall", 32'(dif.stall_out), 32'd0);
    chk("post_hold_req", 32'(dif.bus_req_out), 32'd0);
    chk("post_hold_rdval", dif.core_read_value_out, 32'd0);
    step();
    // timeout: no ack ever
    access(1'b0, 32'h0000_0BAD, 4'h0, 32'h0, 32'h0, 1000, -1, 1);
    // ack and error together -> error
    access(1'b0, 32'h0000_0C00, 4'h0, 32'h0, 32'hFFFF_FFFF, 1, 1, 0);

    // reset during REQ
    dif.core_read_in    = 1'b1;
    dif.core_address_in = 32'h0000_0400;
    dif.stall_in        = 1'b1;
    step();
    #1;
    chk("mid_req", 32'(dif.bus_req_out), 32'd1);
    quiet_inputs();
    reset_n = 1'b0;
    #1;
    chk("arst_req", 32'(dif.bus_req_out), 32'd0);
    chk("arst_stall", 32'(dif.stall_out), 32'd0);
    chk("arst_faddr", dif.fault_address_out, 32'd0);
    exp_rd = 32'd0;
    exp_fa = 32'd0;
    step();
    reset_n = 1'b1;
    step();
    access(1'b0, 32'h0000_0408, 4'h0, 32'h0, 32'hCAFE_F00D, 2, -1, 0);

    // randomized back-to-back accesses
    for (int i = 0; i < 80; i++) begin
      access(1'($urandom), $urandom, 4'($urandom), $urandom, $urandom,
             $urandom_range(0, 5),
             ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 5)) : -1,
             $urandom_range(0, 3));
    end

    quiet_inputs();
    step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/rv32_dbus_bridge.md
Name: rv32_dbus_bridge

Overview:
- Sits between the memory stage's single-cycle data port and an external request/acknowledge data bus with variable wait states.
- Captures each load/store, issues it on the bus, and stalls the pipeline through the hazard unit until the bus acknowledges.
- Holds read data for the memory stage, and guarantees each access is issued exactly once however long the pipeline stays stalled.
- A watchdog aborts hung transactions and reports a fault.

Parameters:
- TIMEOUT, 255: maximum cycles spent waiting for acknowledge in REQ; 0 disables the watchdog.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- stall_in  input  1  global pipeline stall from the hazard unit (includes this block's stall_out).
- core_read_in  input  1  load request from the memory stage.
- core_write_in  input  1  store request from the memory stage.
- core_write_mask_in  input  4  byte lane enables for stores.
- core_address_in  input  32  byte address.
- core_write_value_in  input  32  lane-aligned store data.
- core_read_value_out  output  32  raw 32-bit word returned to the memory stage.
- stall_out  output  1  to the hazard unit: access not yet complete.
- bus_req_out  output  1  bus request.
- bus_write_out  output  1  1 = write, 0 = read.
- bus_sel_out  output  4  byte selects.
- bus_address_out  output  32  word-aligned address.
- bus_write_value_out  output  32  store data.
- bus_ack_in  input  1  transfer complete.
- bus_error_in  input  1  transfer terminated with error.
- bus_read_value_in  input  32  read data, valid with bus_ack_in.
- fault_out  output  1  one-cycle pulse on timeout or bus error.
- fault_address_out  output  32  byte address of the most recent faulting access.

Behaviour:
- Reset (asynchronous, takes effect immediately, including mid-transaction):
  - state = IDLE; bus_req_out, fault_out, watchdog counter = 0.
  - Captured address, data, mask, write flag, read-data register and fault_address_out = 0.
- States: IDLE, REQ, DONE.
- IDLE:
  - Request = core_read_in | core_write_in. stall_out = request, combinationally.
  - On a request edge: latch address, write data, write flag and select; clear the counter; go to REQ.
  - Write flag = core_write_in; write wins if both are asserted.
  - Select = core_write_mask_in for writes, 4'b1111 for reads.
- REQ:
  - bus_req_out = 1, driven from the latched registers; stall_out = 1.
  - bus_address_out = {addr[31:2], 2'b00}.
  - Latched values are stable for the whole REQ state, regardless of core input changes.
  - bus_ack_in: capture bus_read_value_in into the read register (writes capture nothing); go to DONE.
  - bus_error_in, or ack and error together: read register = 0, fault_out = 1 on the next cycle, fault_address_out = latched address; go to DONE. Error has priority.
  - Watchdog: counter increments each REQ cycle. If TIMEOUT != 0 and the counter reaches TIMEOUT-1 without ack or error, treat it as an error (same actions as above).
  - Maximum REQ residency = TIMEOUT cycles.
- DONE:
  - stall_out = 0, bus_req_out = 0; core_read_value_out = read register.
  - If !stall_in at the edge, go to IDLE. Otherwise stay in DONE, with no reissue and the data held.
- bus_ack_in and bus_error_in are ignored outside REQ.
- fault_out is registered and high for exactly one cycle: the first cycle in DONE after a fault.
- core_read_value_out is 0 in IDLE and REQ; it is meaningful only in DONE.
- Latency:
  - Request seen in IDLE at cycle 0, bus_req_out high from cycle 1.
  - With ack at cycle 1+N, DONE at cycle 2+N.
  - stall_out is high for cycles 0 through 1+N.
- Back-to-back: after DONE→IDLE, a new request present in IDLE is accepted that same cycle. There is no idle bubble beyond the IDLE cycle.

Test Plan:
- Zero-wait read:
  - Stimulus: core_read_in=1, address 0x00001006, bus_ack_in asserted in the first REQ cycle with data 0xA1B2C3D4.
  - Required: bus_address_out 0x00001004, bus_sel_out 1111, stall_out high for 2 cycles, core_read_value_out 0xA1B2C3D4 in DONE.
- Write with 3 wait states:
  - Stimulus: core_write_in=1, mask 0100, value 0x00EE0000, address 0x20.
  - Required: bus_write_out=1, bus_sel_out 0100, bus_req_out high for 4 cycles, stall_out high for 5 cycles.
- Stall hold:
  - Stimulus: keep stall_in=1 for 6 cycles after DONE.
  - Required: bus_req_out stays 0 (single bus transaction); data held; IDLE on the first cycle stall_in=0.
- Timeout:
  - Stimulus: TIMEOUT=4, no ack.
  - Required: bus_req_out high for exactly 4 cycles, then fault_out pulses once, fault_address_out equals the request address, core_read_value_out = 0.
- Bus error:
  - Stimulus: bus_error_in and bus_ack_in asserted together.
  - Required: fault path taken, read data 0.
- Reset mid-REQ:
  - Stimulus: drop reset_n during REQ.
  - Required: bus_req_out and stall_out fall immediately; after release, a new read completes normally.
